sc_ulpi_txsch: RTL and testbench

SC_ULPI_TXSCH -- requirements
Module: sc_ulpi_txsch

---
 rtl/sc_usb_pkg.sv | 33 +++
 rtl/sc_ulpi_frmtmr.sv | 69 ++++++
 rtl/sc_ulpi_txsch.sv | 190 +++++++++++++++++++
 tb/tb_sc_ulpi_txsch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_usb_pkg.sv
// Shared USB definitions for the ULPI transmit path.
// Provides the PID encodings, the transmit scheduler state type, the
// scheduler timing defaults and a counter-width helper.
package sc_usb_pkg;

  typedef enum logic [3:0] {
    tokenOut   = 4'b0001,
    tokenIn    = 4'b1001,
    tokenSof   = 4'b0101,
    tokenSetup = 4'b1101,
    dataData0  = 4'b0011,
    dataData1  = 4'b1011,
    hsAck      = 4'b0010,
    hsNak      = 4'b1010,
    hsStall    = 4'b1110
  } usbPid_t;

  typedef enum logic [1:0] {
    schIdle,
    schSof,
    schTrn,
    schGap
  } schState_t;

  localparam int unsigned FRAME_CYCLES_DEF = 60000;
  localparam int unsigned GUARD_CYCLES_DEF = 3000;
  localparam int unsigned GAP_CYCLES_DEF   = 2;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sc_ulpi_frmtmr.sv
// Frame timer: counts clk cycles within a frame and flags pending SOFs.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   sof_on       - enables counting; when low the counter holds 0 and the
//                  pending flag is cleared
//   sof_clr      - scheduler has taken the pending SOF this cycle
//   cnt          - current position inside the frame
//   sof_pending  - an SOF is owed to the bus
//   sof_miss     - one-cycle pulse: boundary reached while SOF still owed
module sc_ulpi_frmtmr
  import sc_usb_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned CNT_W        = cnt_width(FRAME_CYCLES_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof_on,
  input  logic             sof_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sof_pending,
  output logic             sof_miss
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             miss_q, miss_d;
  logic             last;

  assign last = (cnt_q == CNT_W'(FRAME_CYCLES - 1));

  // A boundary that coincides with the scheduler taking the old SOF
  // re-arms the flag without counting a miss.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    miss_d = 1'b0;
    if (!sof_on) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else begin
      if (sof_clr) pend_d = 1'b0;
      if (last) begin
        cnt_d  = '0;
        miss_d = pend_q && !sof_clr;
        pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      miss_q <= miss_d;
    end
  end

  assign cnt         = cnt_q;
  assign sof_pending = pend_q;
  assign sof_miss    = miss_q;

endmodule

// File: rtl/sc_ulpi_txsch.sv
// ULPI transmit scheduler: arbitrates between frame SOFs and requested
// transactions and drives the packet generator request interface.
// Optional feature macro: SC_ULPI_TXSCH_SOF_EN (frame timer, SOF issue,
// guard window). Without it SOF_ON is ignored, FRM_NUM/FRM_SOF/SOF_MISS
// are 0 and requests are granted whenever the scheduler is idle.
// Ports:
//   ULPICLK, ULPIRST         - clock, synchronous active-high reset
//   SOF_ON                   - enable frame timing
//   TRN_REQ/PID/ADR/EPN      - transaction request and fields
//   TRN_GNT, TRN_COMP        - grant / completion pulses
//   FRM_NUM, FRM_SOF         - frame number, SOF-sent pulse
//   SOF_MISS                 - SOF overrun pulse
//   PKT_TX_START/PID/ADR/EPN/FMN, PKT_TX_COMP - packet generator handshake
module sc_ulpi_txsch
  import sc_usb_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic        ULPICLK,
  input  logic        ULPIRST,
  input  logic        SOF_ON,
  input  logic        TRN_REQ,
  input  logic [3:0]  TRN_PID,
  input  logic [6:0]  TRN_ADR,
  input  logic [3:0]  TRN_EPN,
  output logic        TRN_GNT,
  output logic        TRN_COMP,
  output logic [10:0] FRM_NUM,
  output logic        FRM_SOF,
  output logic        SOF_MISS,
  output logic        PKT_TX_START,
  output logic [3:0]  PKT_TX_PID,
  output logic [6:0]  PKT_TX_ADR,
  output logic [3:0]  PKT_TX_EPN,
  output logic [10:0] PKT_TX_FMN,
  input  logic        PKT_TX_COMP
);

  localparam int unsigned CNT_W = cnt_width(FRAME_CYCLES);
  localparam int unsigned GAP_W = cnt_width(GAP_CYCLES + 1);

  schState_t        st_q, st_d;
  logic             start_q, start_d;
  logic [3:0]       pid_q, pid_d;
  logic [6:0]       adr_q, adr_d;
  logic [3:0]       epn_q, epn_d;
  logic [10:0]      fmn_q, fmn_d;
  logic             gnt_q, gnt_d;
  logic             tcomp_q, tcomp_d;
  logic             fsof_q, fsof_d;
  logic [10:0]      frm_num_q, frm_num_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic sof_pend;
  logic sof_clr;
  logic sof_miss;
  logic grant_ok;

`ifdef SC_ULPI_TXSCH_SOF_EN
  logic [CNT_W-1:0] frm_cnt;

  sc_ulpi_frmtmr #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .CNT_W        (CNT_W)
  ) u_frmtmr (
    .clk         (ULPICLK),
    .rst         (ULPIRST),
    .sof_on      (SOF_ON),
    .sof_clr     (sof_clr),
    .cnt         (frm_cnt),
    .sof_pending (sof_pend),
    .sof_miss    (sof_miss)
  );

  // New transactions are held off near frame end so the SOF is not delayed.
  assign grant_ok = !SOF_ON || (32'(frm_cnt) < FRAME_CYCLES - GUARD_CYCLES);
  assign FRM_NUM  = frm_num_q;
  assign FRM_SOF  = fsof_q;
  assign SOF_MISS = sof_miss;
`else
  localparam int unsigned unused_guard = GUARD_CYCLES;
  logic unused_sof;
  assign sof_pend   = 1'b0;
  assign sof_miss   = 1'b0;
  assign grant_ok   = 1'b1;
  assign unused_sof = ^{SOF_ON, sof_clr, sof_miss, frm_num_q, fsof_q};
  assign FRM_NUM    = '0;
  assign FRM_SOF    = 1'b0;
  assign SOF_MISS   = 1'b0;
`endif

  always_comb begin
    st_d      = st_q;
    start_d   = start_q;
    pid_d     = pid_q;
    adr_d     = adr_q;
    epn_d     = epn_q;
    fmn_d     = fmn_q;
    gnt_d     = 1'b0;
    tcomp_d   = 1'b0;
    fsof_d    = 1'b0;
    frm_num_d = frm_num_q;
    gap_d     = gap_q;
    sof_clr   = 1'b0;
    unique case (st_q)
      schIdle: begin
        if (sof_pend) begin
          st_d    = schSof;
          start_d = 1'b1;
          pid_d   = tokenSof;
          adr_d   = '0;
          epn_d   = '0;
          fmn_d   = frm_num_q;
          sof_clr = 1'b1;
        end else if (TRN_REQ && grant_ok) begin
          st_d    = schTrn;
          start_d = 1'b1;
          gnt_d   = 1'b1;
          pid_d   = TRN_PID;
          adr_d   = TRN_ADR;
          epn_d   = TRN_EPN;
          fmn_d   = '0;
        end
      end
      schSof, schTrn: begin
        if (PKT_TX_COMP) begin
          st_d    = schGap;
          start_d = 1'b0;
          pid_d   = '0;
          adr_d   = '0;
          epn_d   = '0;
          fmn_d   = '0;
          gap_d   = '0;
          if (st_q == schSof) begin
            fsof_d    = 1'b1;
            frm_num_d = frm_num_q + 11'd1;
          end else begin
            tcomp_d = 1'b1;
          end
        end
      end
      schGap: begin
        // The gap state always lasts at least one cycle, so GAP_CYCLES=0
        // returns to idle on the next cycle.
        if (32'(gap_q) + 32'd1 >= GAP_CYCLES) st_d = schIdle;
        else                                  gap_d = gap_q + 1'b1;
      end
      default: st_d = schIdle;
    endcase
  end

  always_ff @(posedge ULPICLK) begin
    if (ULPIRST) begin
      st_q      <= schIdle;
      start_q   <= 1'b0;
      pid_q     <= '0;
      adr_q     <= '0;
      epn_q     <= '0;
      fmn_q     <= '0;
      gnt_q     <= 1'b0;
      tcomp_q   <= 1'b0;
      fsof_q    <= 1'b0;
      frm_num_q <= '0;
      gap_q     <= '0;
    end else begin
      st_q      <= st_d;
      start_q   <= start_d;
      pid_q     <= pid_d;
      adr_q     <= adr_d;
      epn_q     <= epn_d;
      fmn_q     <= fmn_d;
      gnt_q     <= gnt_d;
      tcomp_q   <= tcomp_d;
      fsof_q    <= fsof_d;
      frm_num_q <= frm_num_d;
      gap_q     <= gap_d;
    end
  end

  assign TRN_GNT      = gnt_q;
  assign TRN_COMP     = tcomp_q;
  assign PKT_TX_START = start_q;
  assign PKT_TX_PID   = pid_q;
  assign PKT_TX_ADR   = adr_q;
  assign PKT_TX_EPN   = epn_q;
  assign PKT_TX_FMN   = fmn_q;

endmodule

// File: tb/tb_sc_ulpi_txsch.sv
// Self-checking bench for sc_ulpi_txsch. A main instance (100/20/2) is
// checked every cycle against a behavioural model; a second instance with
// a short frame runs long enough to wrap the 11-bit frame number.
module tb_sc_ulpi_txsch;
  import sc_usb_pkg::*;

  localparam int unsigned FC  = 100;
  localparam int unsigned GC  = 20;
  localparam int unsigned GP  = 2;
  localparam int unsigned WFC = 16;
`ifdef SC_ULPI_TXSCH_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, sof_on, trn_req, tx_comp;
  logic [3:0]  trn_pid, trn_epn;
  logic [6:0]  trn_adr;
  logic        trn_gnt, trn_comp, frm_sof, sof_miss, tx_start;
  logic [10:0] frm_num, tx_fmn;
  logic [3:0]  tx_pid, tx_epn;
  logic [6:0]  tx_adr;

  logic        w_rst, w_sof_on, w_req, w_comp;
  logic [3:0]  w_tpid, w_tepn;
  logic [6:0]  w_tadr;
  logic        w_gnt, w_tcomp, w_fsof, w_miss, w_start;
  logic [10:0] w_num, w_fmn;
  logic [3:0]  w_pid, w_epn;
  logic [6:0]  w_adr;

  always #5 clk = ~clk;

  sc_ulpi_txsch #(.FRAME_CYCLES(FC), .GUARD_CYCLES(GC), .GAP_CYCLES(GP)) u_dut (
    .ULPICLK(clk), .ULPIRST(rst), .SOF_ON(sof_on), .TRN_REQ(trn_req),
    .TRN_PID(trn_pid), .TRN_ADR(trn_adr), .TRN_EPN(trn_epn),
    .TRN_GNT(trn_gnt), .TRN_COMP(trn_comp), .FRM_NUM(frm_num),
    .FRM_SOF(frm_sof), .SOF_MISS(sof_miss), .PKT_TX_START(tx_start),
    .PKT_TX_PID(tx_pid), .PKT_TX_ADR(tx_adr), .PKT_TX_EPN(tx_epn),
    .PKT_TX_FMN(tx_fmn), .PKT_TX_COMP(tx_comp)
  );

  sc_ulpi_txsch #(.FRAME_CYCLES(WFC), .GUARD_CYCLES(4), .GAP_CYCLES(GP)) u_wrap (
    .ULPICLK(clk), .ULPIRST(w_rst), .SOF_ON(w_sof_on), .TRN_REQ(w_req),
    .TRN_PID(w_tpid), .TRN_ADR(w_tadr), .TRN_EPN(w_tepn),
    .TRN_GNT(w_gnt), .TRN_COMP(w_tcomp), .FRM_NUM(w_num),
    .FRM_SOF(w_fsof), .SOF_MISS(w_miss), .PKT_TX_START(w_start),
    .PKT_TX_PID(w_pid), .PKT_TX_ADR(w_adr), .PKT_TX_EPN(w_epn),
    .PKT_TX_FMN(w_fmn), .PKT_TX_COMP(w_comp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_pos, m_num, m_gap;
  int          m_tx;      // 0: nothing on the bus, 1: SOF packet, 2: transaction
  bit          m_pend;
  bit          e_start, e_gnt, e_tcomp, e_fsof, e_miss;
  logic [3:0]  e_pid, e_epn;
  logic [6:0]  e_adr;
  logic [10:0] e_fmn;

  task automatic model_step(input bit r, input bit s_in, input bit req,
                            input logic [3:0] pid, input logic [6:0] adr,
                            input logic [3:0] epn, input bit comp);
    bit s, old_pend, taken;
    s = SOF_EN && s_in;
    if (r) begin
      m_pos = 0; m_pend = 0; m_num = 0; m_tx = 0; m_gap = 0;
      e_start = 0; e_gnt = 0; e_tcomp = 0; e_fsof = 0; e_miss = 0;
      e_pid = '0; e_adr = '0; e_epn = '0; e_fmn = '0;
      return;
    end
    e_gnt = 0; e_tcomp = 0; e_fsof = 0; e_miss = 0;
    taken = 0;
    old_pend = m_pend;
    if (m_tx != 0) begin
      if (comp) begin
        if (m_tx == 1) begin
          e_fsof = 1;
          m_num = (m_num + 1) % 2048;
        end else begin
          e_tcomp = 1;
        end
        m_tx = 0;
        e_start = 0; e_pid = '0; e_adr = '0; e_epn = '0; e_fmn = '0;
        m_gap = (GP == 0) ? 1 : int'(GP);
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (old_pend) begin
      m_tx = 1; taken = 1;
      e_start = 1; e_pid = tokenSof; e_adr = '0; e_epn = '0; e_fmn = 11'(m_num);
    end else if (req && (!s || m_pos < int'(FC - GC))) begin
      m_tx = 2; e_gnt = 1;
      e_start = 1; e_pid = pid; e_adr = adr; e_epn = epn; e_fmn = '0;
    end
    if (!s) begin
      m_pos = 0; m_pend = 0;
    end else begin
      if (taken) m_pend = 0;
      if (m_pos == int'(FC) - 1) begin
        m_pos = 0;
        if (old_pend && !taken) e_miss = 1;
        m_pend = 1;
      end else begin
        m_pos++;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  bit   rsp_busy = 0;
  bit   spur_en = 0;
  int   rsp_cnt = 0;
  int   rsp_delay = 3;
  bit   prev_start = 0;
  int   low_run = 0, last_low_run = 0;
  int   miss_cnt = 0, sof_start_cnt = 0;
  int   sof_fmn_q[$];

  task automatic cycle();
    bit r, s, q, c;
    logic [3:0] p, e;
    logic [6:0] a;
    r = rst; s = sof_on; q = trn_req; p = trn_pid; a = trn_adr; e = trn_epn; c = tx_comp;
    @(posedge clk);
    #1;
    model_step(r, s, q, p, a, e, c);
    chk("outs",
        {tx_start, tx_pid, tx_adr, tx_epn, tx_fmn, trn_gnt, trn_comp, frm_sof, sof_miss, frm_num},
        {e_start, e_pid, e_adr, e_epn, e_fmn, e_gnt, e_tcomp, e_fsof, e_miss, 11'(m_num)});
    if (tx_start && !prev_start) begin
      last_low_run = low_run;
      if (tx_pid == 4'(tokenSof)) begin
        sof_start_cnt++;
        sof_fmn_q.push_back(int'(tx_fmn));
      end
    end
    if (tx_start) low_run = 0; else low_run++;
    if (sof_miss) miss_cnt++;
    if (trn_req && trn_gnt) trn_req = 0;
    if (tx_comp) tx_comp = 0;
    else if (tx_start) begin
      if (!rsp_busy) begin rsp_busy = 1; rsp_cnt = rsp_delay; end
      if (rsp_cnt <= 1) begin tx_comp = 1; rsp_busy = 0; end
      else rsp_cnt--;
    end else if (spur_en && $urandom_range(0, 15) == 0) tx_comp = 1;
    if (r) begin rsp_busy = 0; tx_comp = 0; end
    prev_start = tx_start;
  endtask

  task automatic wait_pos(input string tag, input int p);
`ifdef SC_ULPI_TXSCH_SOF_EN
    for (int i = 0; i < 300 && m_pos != p; i++) cycle();
    if (m_pos != p) chk(tag, 64'(m_pos), 64'(p));
`endif
  endtask

  task automatic request(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    trn_req = 1; trn_pid = p; trn_adr = a; trn_epn = e;
  endtask

  task automatic wait_gnt(input string tag);
    for (int i = 0; i < 400 && !trn_gnt; i++) cycle();
    chk(tag, trn_gnt, 1);
  endtask

  initial begin
    rst = 1; sof_on = 0; trn_req = 0; trn_pid = '0; trn_adr = '0; trn_epn = '0; tx_comp = 0;
    w_rst = 1; w_sof_on = 0; w_req = 0; w_tpid = '0; w_tadr = '0; w_tepn = '0; w_comp = 0;
    repeat (3) cycle();
    chk("rst_start", tx_start, 0);
    chk("rst_num", frm_num, 0);

    // Free-running SOFs, completion 3 cycles after START
    rst = 0; sof_on = 1;
    repeat (215) cycle();
    chk("s1_sof_count", sof_start_cnt, SOF_EN ? 2 : 0);
    chk("s1_frm_num", frm_num, SOF_EN ? 2 : 0);
`ifdef SC_ULPI_TXSCH_SOF_EN
    chk("s1_fmn0", sof_fmn_q[0], 0);
    chk("s1_fmn1", sof_fmn_q[1], 1);
`endif

    // Transaction early in a frame, then back-to-back request after completion
    wait_pos("s2_pos", 10);
    request(tokenIn, 7'h05, 4'h1);
    wait_gnt("s2_gnt");
    chk("s2_fields", {tx_start, tx_pid, tx_adr, tx_epn, tx_fmn},
        {1'b1, 4'(tokenIn), 7'h05, 4'h1, 11'd0});
    for (int i = 0; i < 20 && !trn_comp; i++) cycle();
    chk("s2_tcomp", trn_comp, 1);
    chk("s2_start_low", tx_start, 0);
    request(tokenOut, 7'h33, 4'h7);
    wait_gnt("s2_gnt2");
    chk("s2_gap_min", last_low_run >= int'(GP), 1);
    repeat (10) cycle();

    // Request inside the guard window waits for the SOF
    wait_pos("s3_pos", 85);
    sof_start_cnt = 0;
    request(tokenSetup, 7'h11, 4'h2);
    wait_gnt("s3_gnt");
    chk("s3_sof_first", sof_start_cnt, SOF_EN ? 1 : 0);
    repeat (10) cycle();

    // Long transaction spanning two boundaries
    wait_pos("s4_pos", 10);
    miss_cnt = 0;
    rsp_delay = 250;
    request(tokenOut, 7'h42, 4'h3);
    wait_gnt("s4_gnt");
    rsp_delay = 3;
    for (int i = 0; i < 400 && !trn_comp; i++) cycle();
    chk("s4_tcomp", trn_comp, 1);
    sof_start_cnt = 0;
    repeat (20) cycle();
    chk("s4_miss_once", miss_cnt, SOF_EN ? 1 : 0);
    chk("s4_one_sof", sof_start_cnt, SOF_EN ? 1 : 0);

`ifdef SC_ULPI_TXSCH_SOF_EN
    // Reset in the middle of an SOF packet
    for (int i = 0; i < 250 && !(tx_start && tx_pid == 4'(tokenSof)); i++) cycle();
    chk("s5_sof_seen", {tx_start, tx_pid}, {1'b1, 4'(tokenSof)});
    rst = 1;
    cycle();
    chk("s5_rst_start", tx_start, 0);
    chk("s5_rst_num", frm_num, 0);
    rst = 0;
`endif

    // Randomized traffic
    spur_en = 1;
    for (int i = 0; i < 4000; i++) begin
      if (!trn_req && $urandom_range(0, 7) == 0)
        request(4'($urandom), 7'($urandom), 4'($urandom));
      rsp_delay = $urandom_range(1, 6);
      if ($urandom_range(0, 499) == 0) sof_on = !sof_on;
      rst = ($urandom_range(0, 1499) == 0);
      cycle();
    end
    rst = 0; spur_en = 0; trn_req = 0;

    // Frame-number wrap on the short-frame instance
    begin
      int sofs = 0;
      int odd = 0;
      @(posedge clk); #1;
      w_rst = 0; w_sof_on = 1;
`ifdef SC_ULPI_TXSCH_SOF_EN
      for (int i = 0; i < 40000 && sofs < 2047; i++) begin
        @(posedge clk); #1;
        if (w_fsof) sofs++;
        odd += int'(w_gnt | w_tcomp | w_miss);
        w_comp = w_start && !w_comp;
      end
      chk("wrap_pre_num", w_num, 2047);
      for (int i = 0; i < 3 * WFC && !w_start; i++) begin
        @(posedge clk); #1;
      end
      chk("wrap_sof_pkt", {w_start, w_pid, w_adr, w_epn, w_fmn},
          {1'b1, 4'(tokenSof), 7'd0, 4'd0, 11'd2047});
      w_comp = 1;
      @(posedge clk); #1;
      w_comp = 0;
      chk("wrap_fsof", w_fsof, 1);
      chk("wrap_num", w_num, 0);
      chk("wrap_odd", odd, 0);
`else
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        sofs += int'(w_fsof | w_start | w_miss | w_gnt | w_tcomp);
        odd += int'(w_num != 0) + int'(w_fmn != 0) + int'({w_pid, w_adr, w_epn} != 0);
      end
      chk("nosof_idle", sofs, 0);
      chk("nosof_fields", odd, 0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
